// File: rtl/alu_issue_if.sv
// Operand/result bundle between the register-read stage, the ALU and writeback.
// master = alu_issue side, slave = surrounding pipeline and ALU.
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_s;
  logic [31:0] in_t;

  logic [1:0]  alu_is_sorf;
  logic [5:0]  alu_instr;
  logic [31:0] alu_s;
  logic [31:0] alu_t;
  logic [31:0] alu_imm;
  logic [4:0]  alu_h;
  logic [31:0] alu_d;

  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [4:0]  res_dest;
  logic        res_we;
  logic [5:0]  res_op;
  logic        res_illegal;

  modport master (
    input  in_valid, in_instr, in_s, in_t, alu_d, res_ready,
    output in_ready, alu_is_sorf, alu_instr, alu_s, alu_t, alu_imm, alu_h,
           res_valid, res_data, res_dest, res_we, res_op, res_illegal
  );

  modport slave (
    output in_valid, in_instr, in_s, in_t, alu_d, res_ready,
    input  in_ready, alu_is_sorf, alu_instr, alu_s, alu_t, alu_imm, alu_h,
           res_valid, res_data, res_dest, res_we, res_op, res_illegal
  );
endinterface

// File: rtl/alu_issue.sv
// Issues one decoded MIPS-style op to the ALU, holds it for the op latency, then parks the ALU
// and presents its result. Optional ALU_ISSUE_ILLEGAL_EN traps ops outside the supported sets.
module alu_issue #(
  parameter int FPU_LAT = 3
) (
  input logic       clk,
  input logic       rstn,
  alu_issue_if.master bus
);
  localparam int CW = (FPU_LAT > 1) ? $clog2(FPU_LAT) : 1;
  localparam logic [CW-1:0] FPU_LAST = CW'(FPU_LAT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          accept, cnt_zero;

  logic [5:0]  op, fn;
  logic [4:0]  rt, rd, sh;
  logic [15:0] imm16;

  logic [1:0]    dec_sorf;
  logic [5:0]    dec_instr;
  logic [31:0]   dec_imm;
  logic [4:0]    dec_dest;
  logic          dec_we;
  logic [CW-1:0] dec_last;
  logic          dec_issue;

  logic [1:0]  sorf_q;
  logic [5:0]  instr_q;
  logic [31:0] s_q, t_q, imm_q;
  logic [4:0]  h_q, dest_q;
  logic        we_q;
  logic [5:0]  op_q;

  assign op    = bus.in_instr[31:26];
  assign rt    = bus.in_instr[20:16];
  assign rd    = bus.in_instr[15:11];
  assign sh    = bus.in_instr[10:6];
  assign fn    = bus.in_instr[5:0];
  assign imm16 = bus.in_instr[15:0];

  // rs is carried by in_s already; the field itself is not needed here
  logic unused_rs;
  assign unused_rs = &{1'b0, bus.in_instr[25:21]};

  always_comb begin
    dec_sorf  = 2'b00;
    dec_instr = op;
    dec_dest  = rt;
    dec_we    = 1'b0;
    dec_last  = '0;
    if (op == 6'h00) begin
      dec_sorf  = 2'b01;
      dec_instr = fn;
      dec_dest  = rd;
      dec_we    = (fn != 6'h08);
    end else if (op == 6'h11) begin
      dec_sorf  = 2'b10;
      dec_instr = fn;
      dec_dest  = sh;
      dec_we    = 1'b1;
      if (fn inside {6'h00, 6'h01, 6'h02, 6'h04}) dec_last = FPU_LAST;
    end else if (op inside {6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0F}) begin
      dec_we = 1'b1;
    end else if (op == 6'h03) begin
      dec_dest = 5'd31;
      dec_we   = 1'b1;
    end
  end

  // logical immediates zero-extend, everything else sign-extends
  assign dec_imm = (op inside {6'h0C, 6'h0D, 6'h0E, 6'h0F}) ? {16'h0000, imm16}
                                                           : {{16{imm16[15]}}, imm16};

`ifdef ALU_ISSUE_ILLEGAL_EN
  logic dec_legal, illegal_q;

  always_comb begin
    dec_legal = 1'b0;
    if (op == 6'h00)
      dec_legal = fn inside {6'h20, 6'h22, 6'h18, 6'h1A, 6'h24, 6'h25, 6'h26,
                             6'h2A, 6'h00, 6'h04, 6'h02, 6'h06, 6'h08};
    else if (op == 6'h11)
      dec_legal = fn inside {6'h00, 6'h01, 6'h02, 6'h03, 6'h04,
                             6'h08, 6'h09, 6'h32, 6'h34, 6'h36};
    else
      dec_legal = op inside {6'h23, 6'h2B, 6'h31, 6'h39, 6'h08, 6'h0C, 6'h0D, 6'h0E,
                             6'h0A, 6'h0F, 6'h04, 6'h05, 6'h06, 6'h07, 6'h03, 6'h3F};
  end
  assign dec_issue = dec_legal;
`else
  assign dec_issue = 1'b1;
`endif

  assign bus.in_ready = (state == IDLE) | ((state == DONE) & bus.res_ready);
  assign accept       = bus.in_valid & bus.in_ready;
  assign cnt_zero     = (cnt == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = EXEC;
      EXEC: if (cnt_zero) state_nx = DONE;
      DONE: if (bus.res_ready) state_nx = bus.in_valid ? EXEC : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt     <= '0;
      sorf_q  <= '0;
      instr_q <= '0;
      s_q     <= '0;
      t_q     <= '0;
      imm_q   <= '0;
      h_q     <= '0;
      dest_q  <= '0;
      we_q    <= 1'b0;
      op_q    <= '0;
`ifdef ALU_ISSUE_ILLEGAL_EN
      illegal_q <= 1'b0;
`endif
    end else if (accept) begin
      cnt    <= dec_issue ? dec_last : '0;
      dest_q <= dec_dest;
      we_q   <= dec_we & dec_issue;
      op_q   <= op;
`ifdef ALU_ISSUE_ILLEGAL_EN
      illegal_q <= ~dec_legal;
`endif
      if (dec_issue) begin
        sorf_q  <= dec_sorf;
        instr_q <= dec_instr;
        s_q     <= bus.in_s;
        t_q     <= bus.in_t;
        imm_q   <= dec_imm;
        h_q     <= sh;
      end else begin
        // trapped op: ALU never sees it, stays parked
        sorf_q  <= '0;
        instr_q <= '0;
        s_q     <= '0;
        t_q     <= '0;
        imm_q   <= '0;
        h_q     <= '0;
      end
    end else if (state == EXEC) begin
      if (cnt_zero) begin
        // park as NOP so the ALU freezes d for the result channel
        sorf_q  <= '0;
        instr_q <= '0;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign bus.alu_is_sorf = sorf_q;
  assign bus.alu_instr   = instr_q;
  assign bus.alu_s       = s_q;
  assign bus.alu_t       = t_q;
  assign bus.alu_imm     = imm_q;
  assign bus.alu_h       = h_q;

  assign bus.res_valid = (state == DONE);
  assign bus.res_dest  = dest_q;
  assign bus.res_we    = we_q;
  assign bus.res_op    = op_q;
`ifdef ALU_ISSUE_ILLEGAL_EN
  assign bus.res_data    = illegal_q ? 32'h0 : bus.alu_d;
  assign bus.res_illegal = illegal_q;
`else
  assign bus.res_data    = bus.alu_d;
  assign bus.res_illegal = 1'b0;
`endif
endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: stand-in ALU, transaction-level reference model, directed and random ops.
module tb_alu_issue;
  localparam int FPU_LAT = 3;
`ifdef ALU_ISSUE_ILLEGAL_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  alu_issue_if bus();
  alu_issue #(.FPU_LAT(FPU_LAT)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  int total = 0, bad = 0, n_sent = 0, n_acc = 0;
  bit rr_rand = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [22:0] m;
    int e;
    p = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin m = p[46:24]; e++; end
    else m = p[45:23];
    return {a[31] ^ b[31], e[7:0], m};
  endfunction

  // stand-in ALU behaviour, applied to whatever is on its inputs
  function automatic logic [31:0] alu_calc(input logic [1:0] sorf, input logic [5:0] ins,
                                           input logic [31:0] s, input logic [31:0] t,
                                           input logic [31:0] imm, input logic [4:0] h);
    logic [31:0] r;
    if (sorf == 2'b01) begin
      case (ins)
        6'h20: r = s + t;
        6'h22: r = s - t;
        6'h18: r = s * t;
        6'h1A: r = (t == 0) ? 32'h0 : s / t;
        6'h24: r = s & t;
        6'h25: r = s | t;
        6'h26: r = s ^ t;
        6'h2A: r = {31'b0, $signed(s) < $signed(t)};
        6'h00: r = t << h;
        6'h04: r = t << s[4:0];
        6'h02: r = t >> h;
        6'h06: r = t >> s[4:0];
        6'h08: r = s;
        default: r = 32'hBAD0_0000 | {26'b0, ins};
      endcase
    end else if (sorf == 2'b10) begin
      case (ins)
        6'h02:   r = fmul(s, t);
        6'h00:   r = s + t;
        default: r = s ^ t ^ {26'b0, ins};
      endcase
    end else begin
      case (ins)
        6'h0C: r = s & imm;
        6'h0D: r = s | imm;
        6'h0E: r = s ^ imm;
        6'h0A: r = {31'b0, $signed(s) < $signed(imm)};
        6'h0F: r = {imm[15:0], 16'h0};
        6'h03: r = s;
        6'h04, 6'h05, 6'h06, 6'h07: r = s - t;
        6'h3F: r = s;
        default: r = s + imm;
      endcase
    end
    return r;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) bus.alu_d <= '0;
    else if (!(bus.alu_is_sorf == 2'b00 && bus.alu_instr == 6'h00))
      bus.alu_d <= alu_calc(bus.alu_is_sorf, bus.alu_instr, bus.alu_s, bus.alu_t, bus.alu_imm, bus.alu_h);
  end

  typedef struct packed {
    logic [5:0]  op;
    logic [1:0]  sorf;
    logic [5:0]  ins;
    logic [31:0] s, t, imm, data;
    logic [4:0]  h, dest;
    logic        we, legal, illegal, issue;
    logic [3:0]  lat;
  } txn_t;

  function automatic txn_t predict(input logic [31:0] i, input logic [31:0] s, input logic [31:0] t);
    txn_t p;
    logic [5:0] op, fn;
    p = '0;
    op = i[31:26];
    fn = i[5:0];
    p.op = op; p.s = s; p.t = t; p.h = i[10:6]; p.lat = 4'd1;
    if (op inside {6'h0C, 6'h0D, 6'h0E, 6'h0F}) p.imm = {16'h0, i[15:0]};
    else p.imm = {{16{i[15]}}, i[15:0]};
    if (op == 6'h00) begin
      p.sorf = 2'b01; p.ins = fn; p.dest = i[15:11]; p.we = (fn != 6'h08);
      p.legal = fn inside {6'h20, 6'h22, 6'h18, 6'h1A, 6'h24, 6'h25, 6'h26, 6'h2A,
                           6'h00, 6'h04, 6'h02, 6'h06, 6'h08};
    end else if (op == 6'h11) begin
      p.sorf = 2'b10; p.ins = fn; p.dest = i[10:6]; p.we = 1'b1;
      p.legal = fn inside {6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h08, 6'h09, 6'h32, 6'h34, 6'h36};
      if (fn inside {6'h00, 6'h01, 6'h02, 6'h04}) p.lat = 4'(FPU_LAT);
    end else begin
      p.sorf = 2'b00; p.ins = op; p.dest = i[20:16];
      p.we = op inside {6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0F, 6'h03};
      if (op == 6'h03) p.dest = 5'd31;
      p.legal = op inside {6'h23, 6'h2B, 6'h31, 6'h39, 6'h08, 6'h0C, 6'h0D, 6'h0E,
                           6'h0A, 6'h0F, 6'h04, 6'h05, 6'h06, 6'h07, 6'h03, 6'h3F};
    end
    p.illegal = ILL_EN && !p.legal;
    p.issue = !p.illegal;
    if (p.illegal) begin
      p.lat = 4'd1; p.data = '0; p.we = 1'b0;
    end else begin
      p.data = alu_calc(p.sorf, p.ins, s, t, p.imm, p.h);
    end
    return p;
  endfunction

  // model: one op in flight, result due lat edges after acceptance
  txn_t in_pred, cur;
  logic pend = 1'b0;
  int   rem = 0;
  logic m_done, m_rdy, m_acc;

  always_comb in_pred = predict(bus.in_instr, bus.in_s, bus.in_t);
  assign m_done = pend && (rem == 0);
  assign m_rdy  = !pend || (m_done && bus.res_ready);
  assign m_acc  = bus.in_valid && m_rdy;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend <= 1'b0;
      rem  <= 0;
    end else if (m_acc) begin
      pend  <= 1'b1;
      cur   <= in_pred;
      rem   <= int'(in_pred.lat);
      n_acc <= n_acc + 1;
    end else if (m_done && bus.res_ready) begin
      pend <= 1'b0;
    end else if (pend && rem != 0) begin
      rem <= rem - 1;
    end
  end

  always @(negedge clk) begin
    if (!rstn) begin
      chk("rst_res_valid", bus.res_valid, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_alu_sorf", bus.alu_is_sorf, 0);
      chk("rst_alu_instr", bus.alu_instr, 0);
      chk("rst_alu_s", bus.alu_s, 0);
      chk("rst_alu_t", bus.alu_t, 0);
      chk("rst_alu_imm", bus.alu_imm, 0);
      chk("rst_alu_h", bus.alu_h, 0);
      chk("rst_res_we", bus.res_we, 0);
      chk("rst_res_illegal", bus.res_illegal, 0);
      chk("rst_res_dest", bus.res_dest, 0);
      chk("rst_res_op", bus.res_op, 0);
    end else begin
      chk("in_ready", bus.in_ready, m_rdy);
      chk("res_valid", bus.res_valid, m_done);
      if (pend && rem != 0) begin
        chk("exec_sorf", bus.alu_is_sorf, cur.issue ? cur.sorf : 2'b00);
        chk("exec_instr", bus.alu_instr, cur.issue ? cur.ins : 6'h00);
        if (cur.issue) begin
          chk("exec_s", bus.alu_s, cur.s);
          chk("exec_t", bus.alu_t, cur.t);
          chk("exec_imm", bus.alu_imm, cur.imm);
          chk("exec_h", bus.alu_h, cur.h);
        end
      end else if (m_done) begin
        chk("done_parked_sorf", bus.alu_is_sorf, 0);
        chk("done_parked_instr", bus.alu_instr, 0);
        chk("res_data", bus.res_data, cur.data);
        chk("res_op", bus.res_op, cur.op);
        chk("res_illegal", bus.res_illegal, cur.illegal);
        if (cur.illegal) chk("res_we_illegal", bus.res_we, 0);
        else if (cur.legal) begin
          chk("res_dest", bus.res_dest, cur.dest);
          chk("res_we", bus.res_we, cur.we);
        end
      end
    end
  end

  task automatic rr_step();
    if (rr_rand) bus.res_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      rr_step();
    end
  endtask

  task automatic send(input logic [31:0] i, input logic [31:0] s, input logic [31:0] t, output int cyc);
    bit got;
    got = 1'b0;
    cyc = 0;
    bus.in_valid = 1'b1; bus.in_instr = i; bus.in_s = s; bus.in_t = t;
    while (!got && cyc < 64) begin
      @(negedge clk);
      got = bus.in_ready;
      @(posedge clk); #1;
      cyc++;
      rr_step();
    end
    bus.in_valid = 1'b0;
    chk("send_accepted", got, 1);
    if (got) n_sent++;
  endtask

  logic [5:0] sp_set [13] = '{6'h20, 6'h22, 6'h18, 6'h1A, 6'h24, 6'h25, 6'h26, 6'h2A,
                              6'h00, 6'h04, 6'h02, 6'h06, 6'h08};
  logic [5:0] fp_set [10] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h08, 6'h09, 6'h32, 6'h34, 6'h36};
  logic [5:0] op_set [16] = '{6'h23, 6'h2B, 6'h31, 6'h39, 6'h08, 6'h0C, 6'h0D, 6'h0E,
                              6'h0A, 6'h0F, 6'h04, 6'h05, 6'h06, 6'h07, 6'h03, 6'h3F};

  task automatic add_test();
    int c;
    send(32'h0022_1820, 32'd5, 32'd7, c);
    chk("t1_exec_no_valid", bus.res_valid, 0);
    @(posedge clk); #1;
    chk("t1_valid", bus.res_valid, 1);
    chk("t1_data", bus.res_data, 32'd12);
    chk("t1_dest", bus.res_dest, 5'd3);
    chk("t1_we", bus.res_we, 1);
    idle(1);
  endtask

  initial begin
    int c;
    logic [31:0] r, ins;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_s = '0; bus.in_t = '0;
    bus.res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(1);

    add_test();

    // FMUL 2.0 * 3.0, three-edge hold
    send(32'h4400_0102, 32'h4000_0000, 32'h4040_0000, c);
    repeat (3) begin
      chk("t2_in_ready_low", bus.in_ready, 0);
      chk("t2_no_valid", bus.res_valid, 0);
      @(posedge clk); #1;
    end
    chk("t2_valid", bus.res_valid, 1);
    chk("t2_data", bus.res_data, 32'h40C0_0000);
    chk("t2_dest", bus.res_dest, 5'd4);
    chk("t2_we", bus.res_we, 1);
    idle(1);

    send(32'h3422_FFFF, 32'd0, 32'd0, c);
    chk("t3_ori_imm", bus.alu_imm, 32'h0000_FFFF);
    @(posedge clk); #1;
    chk("t3_ori_data", bus.res_data, 32'h0000_FFFF);
    chk("t3_ori_dest", bus.res_dest, 5'd2);
    idle(1);
    send(32'h2022_FFFF, 32'd0, 32'd0, c);
    chk("t3_addi_imm", bus.alu_imm, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    chk("t3_addi_data", bus.res_data, 32'hFFFF_FFFF);
    idle(1);

    // backpressure in DONE, then release with the next op waiting
    bus.res_ready = 1'b0;
    send(32'h0022_1820, 32'd5, 32'd7, c);
    @(posedge clk); #1;
    repeat (5) begin
      chk("t4_hold_valid", bus.res_valid, 1);
      chk("t4_hold_data", bus.res_data, 32'd12);
      chk("t4_hold_dest", bus.res_dest, 5'd3);
      chk("t4_in_ready", bus.in_ready, 0);
      @(posedge clk); #1;
    end
    bus.res_ready = 1'b1;
    send(32'h0022_1820, 32'd1, 32'd2, c);
    chk("t4_accept_cycles", c, 1);
    @(posedge clk); #1;
    chk("t4_next_data", bus.res_data, 32'd3);
    idle(1);

    // reset during the second EXEC cycle of an FMUL
    send(32'h4400_0102, 32'h4000_0000, 32'h4040_0000, c);
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    chk("t5_valid", bus.res_valid, 0);
    chk("t5_sorf", bus.alu_is_sorf, 0);
    chk("t5_instr", bus.alu_instr, 0);
    chk("t5_alu_s", bus.alu_s, 0);
    chk("t5_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    rstn = 1'b1;
    idle(1);
    add_test();

    // fpu ABS, outside the supported set
    send(32'h4400_0005, 32'd3, 32'd4, c);
    @(posedge clk); #1;
    chk("t6_valid", bus.res_valid, 1);
    if (ILL_EN) begin
      chk("t6_illegal", bus.res_illegal, 1);
      chk("t6_data", bus.res_data, 0);
      chk("t6_we", bus.res_we, 0);
    end else begin
      chk("t6_illegal", bus.res_illegal, 0);
    end
    idle(1);

    rr_rand = 1'b1;
    for (int n = 0; n < 300; n++) begin
      r = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2: ins = {6'h00, r[25:6], sp_set[$urandom_range(0, 12)]};
        3, 4:    ins = {6'h11, r[25:6], fp_set[$urandom_range(0, 9)]};
        5, 6, 7, 8: ins = {op_set[$urandom_range(0, 15)], r[25:0]};
        default: ins = $urandom;
      endcase
      send(ins, $urandom, $urandom, c);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    rr_rand = 1'b0;
    bus.res_ready = 1'b1;
    idle(8);
    chk("accept_count", n_acc, n_sent);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before 500000");
    $fatal(1, "watchdog");
  end
endmodule
